// File: rtl/display_scheduler.sv
// Time-shares a 32-bit hex display word between four requesters using round-robin
// arbitration with a programmable dwell time, plus freeze (hold) and manual-select modes.
module display_scheduler #(
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] src3,
  input  logic [3:0]  req,
  input  logic        hold,
  input  logic        manual,
  input  logic [1:0]  sel,
  output logic [31:0] register,
  output logic [3:0]  grant,
  output logic [1:0]  active_src,
  output logic        rotate
);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_MANUAL
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  active_q, active_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        rotate_q, rotate_d;
  logic [31:0] register_q, register_d;
  logic [31:0] src_sel;
  logic [2:0]  pick_any;
  logic [2:0]  pick_other;

  // Returns {found, index} of the first set bit searching upward from p+1 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    case (active_q)
      2'd0:    src_sel = src0;
      2'd1:    src_sel = src1;
      2'd2:    src_sel = src2;
      default: src_sel = src3;
    endcase
  end

  // Next-state, grant and dwell-counter logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    active_d   = active_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    pick_any   = rr_pick(req, ptr_q);
    pick_other = rr_pick(req & ~grant_q, ptr_q);

    if (manual) begin
      state_d  = ST_MANUAL;
      grant_d  = 4'b0001 << sel;
      active_d = sel;
      ptr_d    = sel;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any[2]) begin
            state_d  = ST_SHOW;
            grant_d  = 4'b0001 << pick_any[1:0];
            active_d = pick_any[1:0];
            ptr_d    = pick_any[1:0];
            cnt_d    = DWELL_LOAD;
          end
        end
        ST_SHOW: begin
          if (!req[active_q]) begin
            // Granted requester withdrew: re-arbitrate even while held.
            if (pick_any[2]) begin
              grant_d  = 4'b0001 << pick_any[1:0];
              active_d = pick_any[1:0];
              ptr_d    = pick_any[1:0];
              cnt_d    = DWELL_LOAD;
            end else begin
              state_d  = ST_IDLE;
              grant_d  = 4'b0000;
              active_d = 2'd0;
              cnt_d    = '0;
            end
          end else if (!hold) begin
            if (cnt_q == '0) begin
              if (pick_other[2]) begin
                grant_d  = 4'b0001 << pick_other[1:0];
                active_d = pick_other[1:0];
                ptr_d    = pick_other[1:0];
              end
              cnt_d = DWELL_LOAD;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_d  = ST_IDLE;
          grant_d  = 4'b0000;
          active_d = 2'd0;
          ptr_d    = active_q;
          cnt_d    = '0;
        end
      endcase
    end

    rotate_d   = (grant_d != grant_q);
    // Blank on the same edge the grant drops; otherwise show last cycle's granted data.
    register_d = ((grant_q != 4'b0000) && (grant_d != 4'b0000)) ? src_sel : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= 4'b0000;
      active_q   <= 2'd0;
      ptr_q      <= 2'd3;
      cnt_q      <= '0;
      rotate_q   <= 1'b0;
      register_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      active_q   <= active_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      rotate_q   <= rotate_d;
      register_q <= register_d;
    end
  end

  assign register   = register_q;
  assign grant      = grant_q;
  assign active_src = active_q;
  assign rotate     = rotate_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed self-checking bench for display_scheduler with a 4-cycle dwell.
module tb_display_scheduler;

  localparam logic [31:0] S0 = 32'h12345678;
  localparam logic [31:0] S1 = 32'h9ABCDEF0;
  localparam logic [31:0] S2 = 32'h0BADF00D;
  localparam logic [31:0] S3 = 32'hCAFEBABE;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src0, src1, src2, src3;
  logic [3:0]  req;
  logic        hold;
  logic        manual;
  logic [1:0]  sel;
  logic [31:0] register;
  logic [3:0]  grant;
  logic [1:0]  active_src;
  logic        rotate;

  int checks = 0;
  int errors = 0;

  display_scheduler #(.DWELL_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .src0(src0), .src1(src1), .src2(src2), .src3(src3),
    .req(req), .hold(hold), .manual(manual), .sel(sel),
    .register(register), .grant(grant), .active_src(active_src), .rotate(rotate)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] src_of(input int idx);
    case (idx)
      0:       return S0;
      1:       return S1;
      2:       return S2;
      default: return S3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0000; hold = 1'b0; manual = 1'b0; sel = 2'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    src0 = S0; src1 = S1; src2 = S2; src3 = S3;
    reset = 1'b1; req = 4'b1111; hold = 1'b0; manual = 1'b0; sel = 2'd0;
    tick(); tick();
    checks++;
    if (grant !== 4'b0000 || register !== 32'h0 || active_src !== 2'd0 || rotate !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: grant=%b reg=%h act=%0d rot=%b, want 0000/0/0/0", grant, register, active_src, rotate);
    end
    req = 4'b0000;
    reset = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0000 || rotate !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: grant=%b rot=%b, want 0000/0", grant, rotate);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001 || rotate !== 1'b1 || register !== 32'h0) begin
      errors++;
      $display("FAIL single_grant: grant=%b rot=%b reg=%h, want 0001/1/0", grant, rotate, register);
    end
    tick();
    checks++;
    if (register !== S0 || rotate !== 1'b0) begin
      errors++;
      $display("FAIL single_register: reg=%h rot=%b, want %h/0", register, rotate, S0);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || rotate !== 1'b0 || register !== S0) begin
        errors++;
        $display("FAIL single_hold_grant[%0d]: grant=%b rot=%b reg=%h, want 0001/0/%h", i, grant, rotate, register, S0);
      end
    end
  endtask

  task automatic test_round_robin();
    int seq [4];
    logic [3:0] exp_g;
    logic [31:0] exp_r;
    seq[0] = 0; seq[1] = 1; seq[2] = 3; seq[3] = 0;
    do_reset();
    req = 4'b1011;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_g = 4'b0001 << seq[i/4];
      if (i == 0) exp_r = 32'h0;
      else if (i % 4 == 0) exp_r = src_of(seq[i/4 - 1]);
      else exp_r = src_of(seq[i/4]);
      checks++;
      if (grant !== exp_g || rotate !== (i % 4 == 0) || register !== exp_r || active_src !== 2'(seq[i/4])) begin
        errors++;
        $display("FAIL rr_seq[%0d]: grant=%b rot=%b reg=%h act=%0d, want %b/%b/%h/%0d",
                 i, grant, rotate, register, active_src, exp_g, (i % 4 == 0), exp_r, seq[i/4]);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    req = 4'b0011;
    tick();
    tick();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || rotate !== 1'b0) begin
        errors++;
        $display("FAIL hold_frozen[%0d]: grant=%b rot=%b, want 0001/0", i, grant, rotate);
      end
    end
    hold = 1'b0;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL hold_resume: grant=%b, want 0001", grant);
    end
    tick();
    checks++;
    if (grant !== 4'b0010 || rotate !== 1'b1) begin
      errors++;
      $display("FAIL hold_rotate: grant=%b rot=%b, want 0010/1", grant, rotate);
    end
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    req = 4'b0100;
    hold = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0100 || rotate !== 1'b1 || active_src !== 2'd2) begin
      errors++;
      $display("FAIL drop_regrant: grant=%b rot=%b act=%0d, want 0100/1/2", grant, rotate, active_src);
    end
    hold = 1'b0;
    req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0100 || rotate !== 1'b0) begin
        errors++;
        $display("FAIL drop_reload[%0d]: grant=%b rot=%b, want 0100/0", i, grant, rotate);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || rotate !== 1'b1 || register !== S2) begin
      errors++;
      $display("FAIL drop_expire: grant=%b rot=%b reg=%h, want 0001/1/%h", grant, rotate, register, S2);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || register !== 32'h0 || rotate !== 1'b1 || active_src !== 2'd0) begin
      errors++;
      $display("FAIL drop_all: grant=%b reg=%h rot=%b act=%0d, want 0000/0/1/0", grant, register, rotate, active_src);
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || rotate !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: grant=%b rot=%b, want 0000/0", grant, rotate);
    end
  endtask

  task automatic test_manual();
    do_reset();
    req = 4'b0001; manual = 1'b1; sel = 2'd2;
    tick();
    checks++;
    if (grant !== 4'b0100 || rotate !== 1'b1 || active_src !== 2'd2) begin
      errors++;
      $display("FAIL manual_enter: grant=%b rot=%b act=%0d, want 0100/1/2", grant, rotate, active_src);
    end
    tick();
    checks++;
    if (register !== S2 || rotate !== 1'b0) begin
      errors++;
      $display("FAIL manual_reg: reg=%h rot=%b, want %h/0", register, rotate, S2);
    end
    sel = 2'd3;
    tick();
    checks++;
    if (grant !== 4'b1000 || rotate !== 1'b1 || register !== S2) begin
      errors++;
      $display("FAIL manual_sel: grant=%b rot=%b reg=%h, want 1000/1/%h", grant, rotate, register, S2);
    end
    tick();
    checks++;
    if (register !== S3 || rotate !== 1'b0) begin
      errors++;
      $display("FAIL manual_sel_reg: reg=%h rot=%b, want %h/0", register, rotate, S3);
    end
    manual = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0000 || rotate !== 1'b1 || register !== 32'h0) begin
      errors++;
      $display("FAIL manual_exit: grant=%b rot=%b reg=%h, want 0000/1/0", grant, rotate, register);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || rotate !== 1'b1 || active_src !== 2'd0) begin
      errors++;
      $display("FAIL manual_resume: grant=%b rot=%b act=%0d, want 0001/1/0", grant, rotate, active_src);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 4'b0010 || register !== S1) begin
      errors++;
      $display("FAIL midreset_pre: grant=%b reg=%h, want 0010/%h", grant, register, S1);
    end
    reset = 1'b1;
    req = 4'b1111;
    tick();
    checks++;
    if (grant !== 4'b0000 || register !== 32'h0 || rotate !== 1'b0 || active_src !== 2'd0) begin
      errors++;
      $display("FAIL midreset_blank: grant=%b reg=%h rot=%b act=%0d, want 0000/0/0/0", grant, register, rotate, active_src);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0001 || rotate !== 1'b1) begin
      errors++;
      $display("FAIL midreset_first: grant=%b rot=%b, want 0001/1", grant, rotate);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_drop();
    test_manual();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
